// File: rtl/spi_slave_if.sv
// ---------------------------------------------------------------------------
// spi_slave_if : SPI pins plus the tx/rx user handshake of spi_slave
// Revision     : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface spi_slave_if #(
  parameter int WIDTH = 8
);
  logic             sck;
  logic             cs_n;
  logic             mosi;
  logic             miso;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;
  logic             underrun;
  logic             aborted;

  modport master (
    output sck, cs_n, mosi, tx_data, tx_load,
    input  miso, tx_ready, rx_data, rx_valid, busy, underrun, aborted
  );

  modport slave (
    input  sck, cs_n, mosi, tx_data, tx_load,
    output miso, tx_ready, rx_data, rx_valid, busy, underrun, aborted
  );
endinterface

`default_nettype wire

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave : oversampled mode-0 LSB-first SPI responder with tx holding reg
// Revision  : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

module spi_slave #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] DEFAULT_TX = '0
) (
  input  logic        sysclk,
  input  logic        rst,
  spi_slave_if.slave  bus
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       sck_sync;
  logic [2:0]       cs_sync;
  logic [1:0]       mosi_sync;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] shift_out;
  logic [WIDTH-1:0] holding;
  logic             hold_full;
  logic [CW-1:0]    bit_cnt;
  logic             word_done;
  logic             miso_bit;
  logic [WIDTH-1:0] rx_word;
  logic             rx_pulse;
  logic             busy_flag;
  logic             underrun_pulse;
  logic             abort_pulse;

  logic             sck_rise;
  logic             sck_fall;
  logic             cs_rise;
  logic             cs_fall;
  logic             word_start;
  logic [WIDTH-1:0] next_word;

  // Edges compare the second synchroniser stage against a delayed third stage.
  assign sck_rise  = sck_sync[1] & ~sck_sync[2];
  assign sck_fall  = ~sck_sync[1] & sck_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];

  assign word_start = ((state == IDLE) && cs_fall) ||
                      ((state == ACTIVE) && !cs_rise && word_done);
  assign next_word  = hold_full ? holding : DEFAULT_TX;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state          <= WAIT_IDLE;
      sck_sync       <= '0;
      cs_sync        <= '0;
      mosi_sync      <= '0;
      shift_in       <= '0;
      shift_out      <= '0;
      holding        <= '0;
      hold_full      <= 1'b0;
      bit_cnt        <= '0;
      word_done      <= 1'b0;
      miso_bit       <= 1'b0;
      rx_word        <= '0;
      rx_pulse       <= 1'b0;
      busy_flag      <= 1'b0;
      underrun_pulse <= 1'b0;
      abort_pulse    <= 1'b0;
    end else begin
      sck_sync       <= {sck_sync[1:0], bus.sck};
      cs_sync        <= {cs_sync[1:0], bus.cs_n};
      mosi_sync      <= {mosi_sync[0], bus.mosi};
      rx_pulse       <= 1'b0;
      underrun_pulse <= 1'b0;
      abort_pulse    <= 1'b0;

      if (bus.tx_load && !hold_full) begin
        holding   <= bus.tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        WAIT_IDLE: begin
          busy_flag <= 1'b0;
          miso_bit  <= 1'b0;
          // Wait for a deselected bus so a frame already underway is never joined.
          if (cs_sync[1]) state <= IDLE;
        end
        IDLE: begin
          miso_bit <= 1'b0;
          if (cs_fall) begin
            state     <= ACTIVE;
            busy_flag <= 1'b1;
            bit_cnt   <= '0;
          end
        end
        ACTIVE: begin
          // A completed word is delivered even if cs_n rises in the same cycle.
          if (word_done) begin
            word_done <= 1'b0;
            rx_word   <= shift_in;
            rx_pulse  <= 1'b1;
          end
          if (cs_rise) begin
            state       <= IDLE;
            busy_flag   <= 1'b0;
            miso_bit    <= 1'b0;
            bit_cnt     <= '0;
            abort_pulse <= (bit_cnt != '0);
            shift_in    <= '0;
            shift_out   <= '0;
          end else if (!word_done && sck_rise) begin
            shift_in <= {mosi_sync[1], shift_in[WIDTH-1:1]};
            if (bit_cnt == LAST) begin
              bit_cnt   <= '0;
              word_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (!word_done && sck_fall && (bit_cnt != '0)) begin
            miso_bit <= shift_out[bit_cnt];
          end
        end
        default: state <= WAIT_IDLE;
      endcase

      // Bit 0 goes out immediately so it is stable before the first sck rise.
      if (word_start) begin
        shift_out <= next_word;
        miso_bit  <= next_word[0];
        if (hold_full) hold_full      <= 1'b0;
        else           underrun_pulse <= 1'b1;
      end
    end
  end

  assign bus.miso     = miso_bit;
  assign bus.tx_ready = ~hold_full;
  assign bus.rx_data  = rx_word;
  assign bus.rx_valid = rx_pulse;
  assign bus.busy     = busy_flag;
  assign bus.underrun = underrun_pulse;
  assign bus.aborted  = abort_pulse;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave : directed, table-driven bench for spi_slave
// Revision     : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_slave;

  localparam int W = 8;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  always #5 sysclk = ~sysclk;

  spi_slave_if #(.WIDTH(W)) bus ();

  spi_slave #(.WIDTH(W), .DEFAULT_TX(8'h00)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (bus)
  );

  int checks = 0;
  int passed = 0;

  logic [7:0] rx_q[$];
  int         rx_cnt  = 0;
  int         und_cnt = 0;
  int         abt_cnt = 0;
  realtime    t_valid = 0;
  realtime    t_rise  = 0;
  int         half    = 6;

  always @(negedge sysclk) begin
    if (!rst) begin
      if (bus.rx_valid) begin
        rx_q.push_back(bus.rx_data);
        rx_cnt++;
        t_valid = $realtime;
      end
      if (bus.underrun) und_cnt++;
      if (bus.aborted)  abt_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic load_tx(input logic [7:0] w);
    bus.tx_data = w;
    bus.tx_load = 1'b1;
    wait_cyc(1);
    bus.tx_load = 1'b0;
  endtask

  task automatic frame_begin();
    bus.cs_n = 1'b0;
    wait_cyc(half);
  endtask

  task automatic frame_end();
    wait_cyc(half);
    bus.cs_n = 1'b1;
    wait_cyc(8);
  endtask

  // Acts as the master: miso is sampled just before each sck rise.
  task automatic send_bits(input logic [7:0] m, input int n, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      bus.mosi = m[i];
      wait_cyc(half);
      mi[i]   = bus.miso;
      bus.sck = 1'b1;
      t_rise  = $realtime;
      wait_cyc(half);
      bus.sck = 1'b0;
    end
  endtask

  typedef struct {
    bit         do_load;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    int         exp_und;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] mi, mi2;
    int         rx0, u0, a0, loads;
    logic [7:0] tw[17];
    logic [7:0] mw[16];
    int         base;

    // The word-start after the final word of a frame also counts as underrun
    // when nothing is pending, hence one extra underrun per frame.
    vecs[0] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 1};
    vecs[1] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1};
    vecs[2] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 1};
    vecs[3] = '{1'b0, 8'h00, 8'h7E, 8'h00, 8'h7E, 2};
    vecs[4] = '{1'b1, 8'h81, 8'h18, 8'h81, 8'h18, 1};

    bus.sck = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
    bus.tx_data = '0; bus.tx_load = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
    check("reset miso",     bus.miso,     1'b0);
    check("reset rx_data",  bus.rx_data,  8'h00);
    check("reset rx_valid", bus.rx_valid, 1'b0);
    check("reset tx_ready", bus.tx_ready, 1'b1);
    check("reset busy",     bus.busy,     1'b0);
    check("reset underrun", bus.underrun, 1'b0);
    check("reset aborted",  bus.aborted,  1'b0);
    wait_cyc(6);

    // T1: single word, A5 out / 3C in
    load_tx(8'hA5);
    check("t1 tx_ready after load", bus.tx_ready, 1'b0);
    rx0 = rx_cnt;
    frame_begin();
    check("t1 busy", bus.busy, 1'b1);
    check("t1 tx_ready after word start", bus.tx_ready, 1'b1);
    send_bits(8'h3C, 8, mi);
    frame_end();
    check("t1 miso stream", mi, 8'hA5);
    check("t1 rx count", rx_cnt - rx0, 1);
    check("t1 rx_data", bus.rx_data, 8'h3C);
    check("t1 latency within 4 clk", (t_valid - t_rise) <= 40.0, 1'b1);
    check("t1 busy after frame", bus.busy, 1'b0);

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].do_load) load_tx(vecs[v].tx);
      rx0 = rx_cnt; u0 = und_cnt; a0 = abt_cnt;
      frame_begin();
      send_bits(vecs[v].mosi, 8, mi);
      frame_end();
      check($sformatf("vec%0d miso", v), mi, vecs[v].exp_miso);
      check($sformatf("vec%0d rx count", v), rx_cnt - rx0, 1);
      check($sformatf("vec%0d rx_data", v), bus.rx_data, vecs[v].exp_rx);
      check($sformatf("vec%0d underrun", v), und_cnt - u0, vecs[v].exp_und);
      check($sformatf("vec%0d aborted", v), abt_cnt - a0, 0);
      check($sformatf("vec%0d tx_ready", v), bus.tx_ready, 1'b1);
    end

    // T2: two words, nothing loaded
    rx0 = rx_cnt; u0 = und_cnt;
    frame_begin();
    send_bits(8'h01, 8, mi);
    send_bits(8'h80, 8, mi2);
    frame_end();
    check("t2 miso word0", mi, 8'h00);
    check("t2 miso word1", mi2, 8'h00);
    check("t2 rx count", rx_cnt - rx0, 2);
    check("t2 underrun count", und_cnt - u0, 3);
    check("t2 rx word0", rx_q[rx_q.size()-2], 8'h01);
    check("t2 rx word1", rx_q[rx_q.size()-1], 8'h80);

    // T3: abort after 5 bits, then a clean word
    rx0 = rx_cnt; a0 = abt_cnt;
    frame_begin();
    send_bits(8'hAA, 5, mi);
    frame_end();
    check("t3 aborted", abt_cnt - a0, 1);
    check("t3 no rx_valid", rx_cnt - rx0, 0);
    check("t3 rx_data held", bus.rx_data, 8'h80);
    load_tx(8'h3E);
    rx0 = rx_cnt; a0 = abt_cnt;
    frame_begin();
    send_bits(8'h96, 8, mi);
    frame_end();
    check("t3 next miso", mi, 8'h3E);
    check("t3 next rx_data", bus.rx_data, 8'h96);
    check("t3 next rx count", rx_cnt - rx0, 1);
    check("t3 next aborted", abt_cnt - a0, 0);

    // T4: reset at bit 3 with cs_n held low
    load_tx(8'h77);
    frame_begin();
    send_bits(8'hF0, 3, mi);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check("t4 miso", bus.miso, 1'b0);
    check("t4 rx_data", bus.rx_data, 8'h00);
    check("t4 rx_valid", bus.rx_valid, 1'b0);
    check("t4 tx_ready", bus.tx_ready, 1'b1);
    check("t4 busy", bus.busy, 1'b0);
    rx0 = rx_cnt; u0 = und_cnt; a0 = abt_cnt;
    send_bits(8'h1F, 5, mi);
    send_bits(8'hFF, 8, mi2);
    check("t4 ignored rx", rx_cnt - rx0, 0);
    check("t4 ignored busy", bus.busy, 1'b0);
    check("t4 ignored miso", mi2, 8'h00);
    check("t4 ignored flags", (und_cnt - u0) + (abt_cnt - a0), 0);
    frame_end();
    load_tx(8'h42);
    frame_begin();
    send_bits(8'h24, 8, mi);
    frame_end();
    check("t4 rearm miso", mi, 8'h42);
    check("t4 rearm rx_data", bus.rx_data, 8'h24);

    // T5: second load while holding is full is dropped
    load_tx(8'hC5);
    load_tx(8'h3A);
    check("t5 tx_ready", bus.tx_ready, 1'b0);
    frame_begin();
    send_bits(8'h5A, 8, mi);
    frame_end();
    check("t5 miso original", mi, 8'hC5);
    check("t5 rx_data", bus.rx_data, 8'h5A);

    // T6: sysclk = 4 x sck, 16 back-to-back words with continuous reload
    half = 2;
    for (int k = 0; k < 17; k++) tw[k] = 8'($urandom);
    for (int k = 0; k < 16; k++) mw[k] = 8'($urandom);
    load_tx(tw[0]);
    rx0 = rx_cnt; u0 = und_cnt; loads = 0;
    base = rx_q.size();
    frame_begin();
    fork
      begin
        for (int k = 1; k < 17; k++) begin
          int n = 0;
          while (!bus.tx_ready && n < 2000) begin
            wait_cyc(1);
            n++;
          end
          if (n < 2000) begin
            load_tx(tw[k]);
            loads++;
          end
        end
      end
      begin
        logic [7:0] dummy;
        for (int k = 0; k < 16; k++) send_bits(mw[k], 8, dummy);
      end
    join
    frame_end();
    check("t6 reloads", loads, 16);
    check("t6 rx count", rx_cnt - rx0, 16);
    check("t6 underrun", und_cnt - u0, 0);
    for (int k = 0; k < 16; k++) begin
      if (base + k < rx_q.size())
        check($sformatf("t6 word%0d", k), rx_q[base+k], mw[k]);
      else
        check($sformatf("t6 word%0d missing", k), rx_q.size(), base + k + 1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
